// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline controller: FSM state encoding,
// next-PC select encodings and the default drain depth.
package pipe_pkg;

    localparam int DRAIN_CYCLES_DEF = 2;
    localparam int CNT_W            = 3;

    localparam logic [1:0] PCSEL_INC = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_VEC = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAIN      = 3'd1,
        ST_SAVE_PC    = 3'd2,
        ST_SAVE_FLAGS = 3'd3,
        ST_VECTOR     = 3'd4
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the datapath/hazard logic (master) and pipe_ctrl (slave).
// PIPE_CTRL_PERF_EN adds the stall_cnt performance counter.
interface pipe_ctrl_if;
    import pipe_pkg::*;

    // Requests are level signals sampled every cycle; controls are valid in the
    // same cycle they are asserted and carry no handshake of their own.
    logic       hdu_stall;
    logic       branch_taken;
    logic       intr_req;
    logic       rti_ex;

    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic [1:0] pc_sel;
    logic       push_pc;
    logic       push_flags;
    logic       int_ack;
    logic       in_isr;
    state_e     state;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    modport master (
        output hdu_stall, branch_taken, intr_req, rti_ex,
`ifdef PIPE_CTRL_PERF_EN
        input  stall_cnt,
`endif
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, pc_sel,
        input  push_pc, push_flags, int_ack, in_isr, state
    );

    modport slave (
        input  hdu_stall, branch_taken, intr_req, rti_ex,
`ifdef PIPE_CTRL_PERF_EN
        output stall_cnt,
`endif
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush, pc_sel,
        output push_pc, push_flags, int_ack, in_isr, state
    );

endinterface

// File: rtl/pipe_drain_cnt.sv
// Down-counter that times the pipeline drain before interrupt state save.
// Load has priority over decrement; the count holds at zero.
module pipe_drain_cnt
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/interrupt-entry controller.
// Define PIPE_CTRL_PERF_EN to add the saturating stall_cnt counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
)
(
    input  logic          clk,
    input  logic          rst_n,
    pipe_ctrl_if.slave    bus
);

    state_e     state;
    logic       in_isr;
    logic       run;
    logic       cnt_zero;
    logic       accept;
    logic       drain_dec;

    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic [1:0] pc_sel;
    logic       push_pc;
    logic       push_flags;
    logic       int_ack;

    // run stays low until the first edge after reset release, so an interrupt
    // already pending at release is not taken on that edge.
    assign accept = (state == ST_IDLE) && run && bus.intr_req && !in_isr &&
                    !bus.branch_taken && !bus.hdu_stall;

    assign drain_dec = (state == ST_DRAIN);

    pipe_drain_cnt u_drain_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (CNT_W'(DRAIN_CYCLES - 1)),
        .dec      (drain_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            in_isr <= 1'b0;
            run    <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.rti_ex) in_isr <= 1'b0;
                    if (accept)     state  <= ST_DRAIN;
                end
                // A branch resolving in the last drain cycle buys one more drain cycle.
                ST_DRAIN:      if (cnt_zero && !bus.branch_taken) state <= ST_SAVE_PC;
                ST_SAVE_PC:    state <= ST_SAVE_FLAGS;
                ST_SAVE_FLAGS: state <= ST_VECTOR;
                ST_VECTOR: begin
                    in_isr <= 1'b1;
                    state  <= ST_IDLE;
                end
                default:       state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst_n so every control is forced low while reset is held,
    // even if requests are active.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = PCSEL_INC;
        push_pc     = 1'b0;
        push_flags  = 1'b0;
        int_ack     = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (bus.branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        pc_sel      = PCSEL_BR;
                    end else if (bus.hdu_stall) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = bus.branch_taken;
                end
                ST_SAVE_PC: begin
                    pc_stall = 1'b1;
                    push_pc  = 1'b1;
                end
                ST_SAVE_FLAGS: begin
                    pc_stall   = 1'b1;
                    push_flags = 1'b1;
                end
                ST_VECTOR: begin
                    pc_sel      = PCSEL_VEC;
                    int_ack     = 1'b1;
                    if_id_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (pc_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt;
`endif

    assign bus.pc_stall    = pc_stall;
    assign bus.if_id_stall = if_id_stall;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.pc_sel      = pc_sel;
    assign bus.push_pc     = push_pc;
    assign bus.push_flags  = push_flags;
    assign bus.int_ack     = int_ack;
    assign bus.in_isr      = in_isr;
    assign bus.state       = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DRAIN_CYCLES=2); the stall_cnt check is built
// only when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    // Output vector: {pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    //                 pc_sel[1:0], push_pc, push_flags, int_ack, in_isr}
    localparam logic [9:0] NONE = 10'b00_0000_0000;
    localparam logic [9:0] PS   = 10'b10_0000_0000;
    localparam logic [9:0] IS   = 10'b01_0000_0000;
    localparam logic [9:0] IFL  = 10'b00_1000_0000;
    localparam logic [9:0] XF   = 10'b00_0100_0000;
    localparam logic [9:0] VEC  = 10'b00_0010_0000;
    localparam logic [9:0] BR   = 10'b00_0001_0000;
    localparam logic [9:0] PP   = 10'b00_0000_1000;
    localparam logic [9:0] PF   = 10'b00_0000_0100;
    localparam logic [9:0] ACK  = 10'b00_0000_0010;
    localparam logic [9:0] ISR  = 10'b00_0000_0001;

    logic clk;
    logic rst_n;

    logic [9:0] exp_q[$];
    logic [15:0] cnt_q[$];
    int n_checks;
    int n_fail;
    int vec_idx;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: one call is one clock cycle of stimulus plus its expected outputs
    task automatic cyc(input logic rst, input logic hdu, input logic br,
                       input logic intr, input logic rti, input logic [9:0] exp);
        @(posedge clk);
        #1;
        rst_n            = rst;
        bus.hdu_stall    = hdu;
        bus.branch_taken = br;
        bus.intr_req     = intr;
        bus.rti_ex       = rti;
        exp_q.push_back(exp);
    endtask

    task automatic expect_cnt(input logic [15:0] v);
        cnt_q.push_back(v);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [9:0] act;
        logic [9:0] exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_flush,
                   bus.pc_sel, bus.push_pc, bus.push_flags, bus.int_ack, bus.in_isr};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL out_vec[%0d] at %0t: got %b expected %b", vec_idx, $time, act, exp);
            end
            vec_idx++;
        end
`ifdef PIPE_CTRL_PERF_EN
        if (cnt_q.size() > 0) begin
            logic [15:0] ce;
            ce = cnt_q.pop_front();
            n_checks++;
            if (bus.stall_cnt !== ce) begin
                n_fail++;
                $display("FAIL stall_cnt at %0t: got %0d expected %0d", $time, bus.stall_cnt, ce);
            end
        end
`endif
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vec_idx  = 0;
        rst_n            = 1'b0;
        bus.hdu_stall    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.intr_req     = 1'b0;
        bus.rti_ex       = 1'b0;

        // reset holds everything low even with requests active
        cyc(0, 1, 0, 1, 0, NONE);
        cyc(0, 0, 0, 0, 0, NONE);
        // release with intr pending: not taken on the first edge
        cyc(1, 0, 0, 1, 0, NONE);
        cyc(1, 0, 0, 0, 0, NONE);
        // load-use stall, one cycle only
        cyc(1, 1, 0, 0, 0, PS | IS | XF);
        cyc(1, 0, 0, 0, 0, NONE);
        // branch beats stall; branch alone
        cyc(1, 1, 1, 0, 0, IFL | XF | BR);
        cyc(1, 0, 1, 0, 0, IFL | XF | BR);
        cyc(1, 0, 0, 0, 0, NONE);
        // interrupt entry; intr dropped and hdu raised after acceptance
        cyc(1, 0, 0, 1, 0, NONE);
        cyc(1, 1, 0, 0, 0, PS | IFL);
        cyc(1, 0, 0, 0, 0, PS | IFL);
        cyc(1, 1, 0, 0, 0, PS | PP);
        cyc(1, 0, 0, 1, 0, PS | PF);
        cyc(1, 0, 0, 0, 0, VEC | ACK | IFL);
        // no nesting while in_isr; rti clears it, then re-entry
        cyc(1, 0, 0, 1, 0, ISR);
        cyc(1, 0, 0, 1, 0, ISR);
        cyc(1, 0, 0, 1, 1, ISR);
        cyc(1, 0, 0, 1, 0, NONE);
        cyc(1, 0, 0, 0, 0, PS | IFL);
        // branch in the final drain cycle extends the drain by one cycle
        cyc(1, 0, 1, 0, 0, PS | IFL | XF);
        cyc(1, 0, 0, 0, 0, PS | IFL);
        cyc(1, 0, 0, 0, 0, PS | PP);
        // reset asserted during SAVE_FLAGS
        cyc(0, 1, 1, 1, 0, NONE);
        cyc(0, 0, 0, 0, 0, NONE);
        cyc(1, 0, 0, 0, 0, NONE);
        // three stalls then a full entry
        cyc(1, 1, 0, 0, 0, PS | IS | XF);
        cyc(1, 0, 0, 0, 0, NONE);
        cyc(1, 1, 0, 0, 0, PS | IS | XF);
        cyc(1, 1, 0, 0, 0, PS | IS | XF);
        cyc(1, 0, 0, 1, 0, NONE);
        cyc(1, 0, 0, 0, 0, PS | IFL);
        cyc(1, 0, 0, 0, 0, PS | IFL);
        cyc(1, 0, 0, 0, 0, PS | PP);
        cyc(1, 0, 0, 0, 0, PS | PF);
        cyc(1, 0, 0, 0, 0, VEC | ACK | IFL);
        cyc(1, 0, 0, 0, 0, ISR);
        expect_cnt(16'd7);
        // reset while in_isr is set, then a fresh entry is accepted
        cyc(0, 0, 0, 1, 0, NONE);
        cyc(1, 0, 0, 1, 0, NONE);
        cyc(1, 0, 0, 1, 0, NONE);
        cyc(1, 0, 0, 0, 0, PS | IFL);
        cyc(1, 0, 0, 0, 0, PS | IFL);

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, shall set the cycles the pipeline drains before interrupt state save (legal range 1..7).
REQ-002 clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  shall be the asynchronous, active-low reset.
REQ-004 hdu_stall  in  1  shall carry the load-use stall request from the hazard detection unit.
REQ-005 branch_taken  in  1  shall indicate that a taken branch, jump, CALL or RET resolved in Execute this cycle.
REQ-006 intr_req  in  1  shall carry the level-sensitive external interrupt request.
REQ-007 rti_ex  in  1  shall indicate that an RTI is in Execute this cycle.
REQ-008 pc_stall, if_id_stall  out  1 each  shall freeze the PC and the IF/ID register.
REQ-009 if_id_flush, id_ex_flush  out  1 each  shall clear the IF/ID and ID/EX registers to NOP.
REQ-010 pc_sel  out  2  shall select the next PC: 00 = PC+1, 01 = branch target, 10 = interrupt vector.
REQ-011 push_pc, push_flags  out  1 each  shall be single-cycle stack-write strobes.
REQ-012 int_ack  out  1  shall pulse for one cycle when the vector is loaded.
REQ-013 in_isr  out  1  shall be high while an interrupt handler is active.

Function
REQ-014 The block shall implement the states IDLE, DRAIN, SAVE_PC, SAVE_FLAGS and VECTOR.
REQ-015 In IDLE, priority shall be branch_taken > hdu_stall > interrupt entry.
REQ-016 IDLE with branch_taken: the block shall assert if_id_flush, id_ex_flush and pc_sel=01 for that cycle only; any hdu_stall in the same cycle shall be ignored.
REQ-017 IDLE with hdu_stall and no branch_taken: the block shall assert pc_stall, if_id_stall and id_ex_flush, all combinational from the inputs in the same cycle.
REQ-018 IDLE with intr_req=1, in_isr=0 and neither branch_taken nor hdu_stall: the block shall go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-019 DRAIN shall assert pc_stall and if_id_flush every cycle and decrement the counter; the block shall go to SAVE_PC when the counter reads 0.
REQ-020 A branch_taken arriving in DRAIN shall additionally assert id_ex_flush, and the block shall remain in DRAIN.
REQ-021 SAVE_PC shall assert push_pc and pc_stall for exactly one cycle, then go to SAVE_FLAGS.
REQ-022 SAVE_FLAGS shall assert push_flags and pc_stall for exactly one cycle, then go to VECTOR.
REQ-023 VECTOR shall assert pc_sel=10, int_ack and if_id_flush for one cycle, set in_isr, and return to IDLE.
REQ-024 Interrupt entry latency shall be DRAIN_CYCLES+3 cycles from acceptance to int_ack.
REQ-025 While in_isr=1, intr_req shall be ignored (no nesting).
REQ-026 rti_ex in IDLE shall clear in_isr on the next edge.
REQ-027 intr_req deasserting after acceptance shall not abort the entry sequence.
REQ-028 hdu_stall and intr_req shall be ignored outside IDLE.
REQ-029 When no condition applies, all strobes shall be 0 and pc_sel shall be 00.

Reset
REQ-030 Asserting rst_n low shall immediately force IDLE, in_isr=0, drain counter=0 and all outputs to 0 (pc_sel=00), including during an entry sequence.
REQ-031 Deasserting rst_n shall take effect on the first rising clk edge; no interrupt shall be accepted on that same edge.

Configuration
REQ-032 With PIPE_CTRL_PERF_EN defined, the block shall add output stall_cnt[15:0], which increments (saturating at 16'hFFFF) on every cycle with pc_stall=1 and resets to 0.
REQ-033 Without PIPE_CTRL_PERF_EN, the stall_cnt port and its logic shall be absent, and all other behaviour shall be identical.

Structure
REQ-034 The shared package pipe_pkg shall hold the FSM state enum, the pc_sel encodings (PCSEL_INC, PCSEL_BR, PCSEL_VEC) and the DRAIN_CYCLES default.
REQ-035 The drain counter shall be an instantiated sub-module, pipe_drain_cnt (load, decrement, zero flag); all other logic shall be flat.

Verification
REQ-036 hdu_stall=1 for 1 cycle in IDLE -> pc_stall=if_id_stall=id_ex_flush=1 in that cycle only, and pc_sel=00.
REQ-037 hdu_stall=1 and branch_taken=1 together -> if_id_flush=id_ex_flush=1, pc_sel=01, pc_stall=0.
REQ-038 intr_req=1 in IDLE with DRAIN_CYCLES=2 -> 2 DRAIN cycles, then push_pc, then push_flags, then int_ack with pc_sel=10 on cycle 5; in_isr=1 afterwards.
REQ-039 intr_req held high with in_isr=1 -> no second entry; rti_ex pulse -> in_isr=0, then re-entry begins on the following IDLE cycle.
REQ-040 rst_n low during SAVE_FLAGS -> all outputs 0 immediately, and after release the state is IDLE with in_isr=0.
REQ-041 PIPE_CTRL_PERF_EN defined, 3 load-use stalls plus 1 interrupt entry with DRAIN_CYCLES=2 -> stall_cnt=7.
